// File: rtl/seg7_if.sv
// Segment-reader handshake bundle: raw segment bus in, decoded result/status out.
// err_cnt exists only when SEG7_READER_ERRCNT_EN is defined.
interface seg7_if;
  logic [6:0] seg_in;
  logic       out_ready;
  logic       ovr_clr;
  logic       out_valid;
  logic [3:0] digit;
  logic       blank;
  logic       err;
  logic       ovr;
`ifdef SEG7_READER_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  modport slave (
    input  seg_in, out_ready, ovr_clr,
    output out_valid, digit, blank, err, ovr
`ifdef SEG7_READER_ERRCNT_EN
    , output err_cnt
`endif
  );

  modport master (
    output seg_in, out_ready, ovr_clr,
    input  out_valid, digit, blank, err, ovr
`ifdef SEG7_READER_ERRCNT_EN
    , input err_cnt
`endif
  );
endinterface

// File: rtl/seg7_reader.sv
// Debounces an active-low 7-segment bus, decodes each newly stable pattern and holds it
// in a one-deep output register with overflow flag. Optional SEG7_READER_ERRCNT_EN adds err_cnt.
module seg7_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic   clk,
  input logic   rst,
  seg7_if.slave bus
);
  localparam logic [6:0] BLANK_CODE = 7'b1111111;
  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t     state_reg, state_next;
  logic [6:0] seg_q;
  logic [6:0] last_acc;
  logic [7:0] stab_cnt;
  logic [3:0] digit_reg;
  logic       blank_reg;
  logic       err_reg;
  logic       ovr_reg;
  logic       load;
  logic       ovr_set;
  logic       stable_now;
  logic       qualify;
  logic [3:0] dec_digit;
  logic       dec_blank;
  logic       dec_err;

  assign stable_now = (bus.seg_in == seg_q);
  // Fires once per new pattern: the count crosses the threshold and the pattern differs from the last one taken
  assign qualify    = stable_now && (stab_cnt == STABLE_MAX - 8'd1) && (seg_q != last_acc);

  always_comb begin
    dec_digit = 4'd0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (seg_q)
      7'b0000001: dec_digit = 4'd0;
      7'b1001111: dec_digit = 4'd1;
      7'b0010010: dec_digit = 4'd2;
      7'b0000110: dec_digit = 4'd3;
      7'b1001100: dec_digit = 4'd4;
      7'b0100100: dec_digit = 4'd5;
      7'b0100000: dec_digit = 4'd6;
      7'b0001111: dec_digit = 4'd7;
      7'b0000000: dec_digit = 4'd8;
      7'b0000100: dec_digit = 4'd9;
      BLANK_CODE: dec_blank = 1'b1;
      default: begin
        dec_digit = 4'hF;
        dec_err   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q    <= BLANK_CODE;
      stab_cnt <= 8'd0;
      last_acc <= BLANK_CODE;
    end else begin
      seg_q <= bus.seg_in;
      if (!stable_now)
        stab_cnt <= 8'd0;
      else if (stab_cnt != STABLE_MAX)
        stab_cnt <= stab_cnt + 8'd1;
      if (qualify)
        last_acc <= seg_q;
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    ovr_set    = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (qualify) begin
          load       = 1'b1;
          state_next = FULL;
        end
      end
      FULL: begin
        if (qualify) begin
          // Held result is never overwritten unless the consumer takes it on this edge
          if (bus.out_ready)
            load = 1'b1;
          else
            ovr_set = 1'b1;
        end else if (bus.out_ready) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
      digit_reg <= 4'd0;
      blank_reg <= 1'b0;
      err_reg   <= 1'b0;
      ovr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        digit_reg <= dec_digit;
        blank_reg <= dec_blank;
        err_reg   <= dec_err;
      end
      if (ovr_set)
        ovr_reg <= 1'b1;
      else if (bus.ovr_clr)
        ovr_reg <= 1'b0;
    end
  end

`ifdef SEG7_READER_ERRCNT_EN
  logic [7:0] err_cnt_reg;

  // Counts illegal qualified patterns, delivered or dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt_reg <= 8'd0;
    else if (qualify && dec_err && err_cnt_reg != 8'hFF)
      err_cnt_reg <= err_cnt_reg + 8'd1;
  end

  assign bus.err_cnt = err_cnt_reg;
`endif

  assign bus.out_valid = (state_reg == FULL);
  assign bus.digit     = digit_reg;
  assign bus.blank     = blank_reg;
  assign bus.err       = err_reg;
  assign bus.ovr       = ovr_reg;
endmodule

// File: tb/tb_seg7_reader.sv
// Directed plus random stimulus for seg7_reader, checked against a run-length reference model.
module tb_seg7_reader;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  seg7_if sif ();

  seg7_reader #(.STABLE_CYCLES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  logic [6:0] codes [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  // Reference model: run length of the sampled value, last accepted pattern, one-deep holder
  logic [6:0] m_prev, m_last;
  int         m_run;
  logic       m_valid, m_blank, m_err, m_ovr;
  logic [3:0] m_digit;
  int         m_errcnt;

  task automatic model_reset();
    m_prev = 7'b1111111; m_run = 1; m_last = 7'b1111111;
    m_valid = 0; m_digit = 0; m_blank = 0; m_err = 0; m_ovr = 0; m_errcnt = 0;
  endtask

  task automatic decode(input logic [6:0] p, output logic [3:0] d, output logic b, output logic e);
    d = 4'hF; b = 0; e = 1;
    if (p == 7'b1111111) begin d = 0; b = 1; e = 0; end
    for (int i = 0; i < 10; i++) if (codes[i] == p) begin d = 4'(i); e = 0; end
  endtask

  task automatic model_edge();
    logic [6:0] v;
    logic ev, ovr_set;
    logic [3:0] d; logic b, e;
    v = sif.seg_in;
    if (v == m_prev) m_run++;
    else begin m_run = 1; m_prev = v; end
    ev = (m_run == S + 1) && (v != m_last);
    ovr_set = 0;
    if (ev) begin
      m_last = v;
      decode(v, d, b, e);
      if (e && m_errcnt < 255) m_errcnt++;
      if (!m_valid || sif.out_ready) begin
        m_valid = 1; m_digit = d; m_blank = b; m_err = e;
      end else ovr_set = 1;
    end else if (m_valid && sif.out_ready) m_valid = 0;
    if (ovr_set) m_ovr = 1;
    else if (sif.ovr_clr) m_ovr = 0;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_all(input string ctx);
    check({ctx, ".out_valid"}, {7'd0, sif.out_valid}, {7'd0, m_valid});
    check({ctx, ".digit"},     {4'd0, sif.digit},     {4'd0, m_digit});
    check({ctx, ".blank"},     {7'd0, sif.blank},     {7'd0, m_blank});
    check({ctx, ".err"},       {7'd0, sif.err},       {7'd0, m_err});
    check({ctx, ".ovr"},       {7'd0, sif.ovr},       {7'd0, m_ovr});
`ifdef SEG7_READER_ERRCNT_EN
    check({ctx, ".err_cnt"},   sif.err_cnt,           8'(m_errcnt));
`endif
  endtask

  task automatic step(input string ctx);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(ctx);
    $display("t=%0t %s seg=%b rdy=%0b clr=%0b -> v=%0b d=%0h b=%0b e=%0b ovr=%0b",
             $time, ctx, sif.seg_in, sif.out_ready, sif.ovr_clr,
             sif.out_valid, sif.digit, sif.blank, sif.err, sif.ovr);
  endtask

  task automatic hold(input string ctx, input logic [6:0] p, input int n);
    sif.seg_in = p;
    repeat (n) step(ctx);
  endtask

  initial begin
    int pulses;
    int errcnt_before;
    sif.seg_in = 7'b1111111; sif.out_ready = 1; sif.ovr_clr = 0;
    model_reset();
    #12;
    compare_all("reset");
    rst = 0;

    // Blank bus after reset produces nothing
    hold("blank_idle", 7'b1111111, 8);

    // Digit 5 after five stable edges, single pulse
    hold("five", 7'b0100100, 5);
    check("five.digit_const", {4'd0, sif.digit}, 8'd5);
    check("five.valid_const", {7'd0, sif.out_valid}, 8'd1);
    step("five_after");
    check("five.pulse_end", {7'd0, sif.out_valid}, 8'd0);

    // Glitch restarts qualification; exactly one event
    pulses = 0;
    sif.seg_in = 7'b0010010;
    for (int i = 0; i < 9; i++) begin
      sif.seg_in = (i == 3) ? 7'b0000110 : 7'b0010010;
      step("glitch");
      if (sif.out_valid) begin
        pulses++;
        check("glitch.digit_const", {4'd0, sif.digit}, 8'd2);
      end
    end
    hold("glitch_tail", 7'b0010010, 6);
    check("glitch.pulses", 8'(pulses), 8'd1);

    // Overflow: 3 held, 7 dropped
    sif.out_ready = 0;
    hold("ovr3", 7'b0000110, 5);
    hold("ovr7", 7'b0001111, 6);
    check("ovr.digit_held", {4'd0, sif.digit}, 8'd3);
    check("ovr.flag", {7'd0, sif.ovr}, 8'd1);
    sif.out_ready = 1;
    step("ovr_drain");
    check("ovr.empty", {7'd0, sif.out_valid}, 8'd0);
    sif.ovr_clr = 1;
    step("ovr_clr");
    sif.ovr_clr = 0;
    check("ovr.cleared", {7'd0, sif.ovr}, 8'd0);

    // Illegal pattern
    errcnt_before = m_errcnt;
    hold("illegal", 7'b1111110, 5);
    check("illegal.err", {7'd0, sif.err}, 8'd1);
    check("illegal.digit", {4'd0, sif.digit}, 8'h0F);
    check("illegal.errcnt_model", 8'(m_errcnt - errcnt_before), 8'd1);
    step("illegal_after");

    // Same-edge accept and replace: hold 1, then 8 qualifies while 1 is taken
    sif.out_ready = 0;
    hold("swap1", 7'b1001111, 5);
    hold("swap8", 7'b0000000, 4);
    sif.out_ready = 1;
    step("swap8_edge");
    check("swap.valid", {7'd0, sif.out_valid}, 8'd1);
    check("swap.digit", {4'd0, sif.digit}, 8'd8);
    check("swap.ovr", {7'd0, sif.ovr}, 8'd0);
    step("swap_after");

    // Asynchronous reset mid-qualification
    hold("rst_pre", 7'b1001100, 2);
    #2 rst = 1;
    model_reset();
    #1 compare_all("async_rst");
    @(posedge clk);
    #3 rst = 0;
    hold("rst_post", 7'b1001100, 5);
    check("rst.digit", {4'd0, sif.digit}, 8'd4);
    check("rst.valid", {7'd0, sif.out_valid}, 8'd1);

    // Random segments: legal/illegal patterns, random hold lengths and consumer behaviour
    for (int seg = 0; seg < 80; seg++) begin
      logic [6:0] p;
      int n;
      p = ($urandom_range(0, 9) < 7) ? codes[$urandom_range(0, 9)] : 7'($urandom);
      n = $urandom_range(1, 7);
      sif.seg_in = p;
      for (int k = 0; k < n; k++) begin
        sif.out_ready = ($urandom_range(0, 1) == 1);
        sif.ovr_clr   = ($urandom_range(0, 9) == 0);
        step("rand");
      end
    end
    sif.ovr_clr = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
